// File: rtl/div_seq.sv
// div_seq: multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU.
// One request in flight; 32 iterations on magnitudes, sign fix-up folded
// into the final iteration. Divide-by-zero and signed overflow bypass CALC.
module div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t      state;
  logic        rem_sel;
  logic        q_neg;
  logic        r_neg;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] dvsr;
  logic [4:0]  count;

  logic        req_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        div_zero;
  logic        overflow;
  logic [31:0] special_res;

  logic [32:0] rem_sh;
  logic [32:0] trial;
  logic [31:0] rem_nx;
  logic [31:0] quo_nx;
  logic [31:0] q_fin;
  logic [31:0] r_fin;

  // Request decode: operand magnitudes and special-case results.
  always_comb begin
    req_signed  = ~req_op[0];
    a_neg       = req_signed & req_a[31];
    b_neg       = req_signed & req_b[31];
    a_mag       = a_neg ? (~req_a + 32'd1) : req_a;
    b_mag       = b_neg ? (~req_b + 32'd1) : req_b;
    div_zero    = (req_b == '0);
    overflow    = req_signed && (req_a == 32'h8000_0000) && (req_b == '1);
    special_res = '0;
    if (div_zero)
      special_res = req_op[1] ? req_a : '1;
    else
      special_res = req_op[1] ? '0 : 32'h8000_0000;
  end

  // One restoring step plus the sign-corrected results of that step.
  always_comb begin
    rem_sh = {rem, quo[31]};
    trial  = rem_sh - {1'b0, dvsr};
    if (!trial[32]) begin
      rem_nx = trial[31:0];
      quo_nx = {quo[30:0], 1'b1};
    end else begin
      rem_nx = rem_sh[31:0];
      quo_nx = {quo[30:0], 1'b0};
    end
    q_fin = q_neg ? (~quo_nx + 32'd1) : quo_nx;
    r_fin = r_neg ? (~rem_nx + 32'd1) : rem_nx;
  end

  // Control FSM with registered handshake outputs and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      busy       <= 1'b0;
      resp_data  <= '0;
      count      <= '0;
      rem_sel    <= 1'b0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
      quo        <= '0;
      rem        <= '0;
      dvsr       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (div_zero || overflow) begin
              resp_data  <= special_res;
              resp_valid <= 1'b1;
              state      <= DONE;
            end else begin
              rem_sel <= req_op[1];
              q_neg   <= a_neg ^ b_neg;
              r_neg   <= a_neg;
              quo     <= a_mag;
              rem     <= '0;
              dvsr    <= b_mag;
              count   <= '0;
              state   <= CALC;
            end
          end
        end
        CALC: begin
          quo   <= quo_nx;
          rem   <= rem_nx;
          count <= count + 5'd1;
          if (count == 5'd31) begin
            resp_data  <= rem_sel ? r_fin : q_fin;
            resp_valid <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq against an arithmetic reference model.
module tb_div_seq;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        busy;

  int checks;
  int failures;

  div_seq dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: RV32M division semantics from plain signed/unsigned arithmetic.
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int signed sa;
    int signed sb;
    sa = a;
    sb = b;
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return op[1] ? 32'h0 : 32'h8000_0000;
    case (op)
      2'b00:   return sa / sb;
      2'b01:   return a / b;
      2'b10:   return sa % sb;
      default: return a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (b == 0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issue one request, collect the result; latency counts the accept edge as 1.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] data, output int lat, output bit timeout);
    int w;
    timeout = 0;
    data = '0;
    lat = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
    w = 0;
    while (!req_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      timeout = 1;
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;
    req_op = 2'($urandom);
    req_a = $urandom;
    req_b = $urandom;
    lat = 1;
    while (!resp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!resp_valid) begin
      timeout = 1;
      return;
    end
    data = resp_data;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_req_ready got=%b exp=1", req_ready);
    end
    checks++;
    if (resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_resp_valid got=%b exp=0", resp_valid);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got=%b exp=0", busy);
    end
    checks++;
    if (resp_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_resp_data got=%h exp=00000000", resp_data);
    end
  endtask

  task automatic test_directed();
    logic [1:0]  ops[10] = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b01, 2'b00, 2'b11,
                             2'b00, 2'b10, 2'b01};
    logic [31:0] as[10]  = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF,
                             32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'h0};
    logic [31:0] bs[10]  = '{32'd7, 32'd7, 32'd2, 32'd2, 32'd2, 32'd0, 32'd0,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3};
    logic [31:0] exp_d[10] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFF,
                               32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0, 32'h0};
    int          exp_l[10] = '{33, 33, 33, 33, 33, 1, 1, 1, 1, 33};
    logic [31:0] d;
    int          lat;
    bit          to;
    for (int i = 0; i < 10; i++) begin
      run_op(ops[i], as[i], bs[i], d, lat, to);
      checks++;
      if (to) begin
        failures++;
        $display("FAIL directed_timeout idx=%0d", i);
        continue;
      end
      if (d !== exp_d[i]) begin
        failures++;
        $display("FAIL directed_data idx=%0d got=%h exp=%h", i, d, exp_d[i]);
      end
      checks++;
      if (lat != exp_l[i]) begin
        failures++;
        $display("FAIL directed_latency idx=%0d got=%0d exp=%0d", i, lat, exp_l[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    int          lat;
    bit          to;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      case ($urandom_range(0, 5))
        0:       a = 32'h8000_0000;
        1:       a = $urandom_range(0, 50);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 6))
        0:       b = 32'h0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = $urandom_range(1, 20);
        3:       b = -$urandom_range(1, 20);
        default: b = $urandom;
      endcase
      run_op(op, a, b, d, lat, to);
      checks++;
      if (to) begin
        failures++;
        $display("FAIL random_timeout op=%0d a=%h b=%h", op, a, b);
        continue;
      end
      if (d !== ref_div(op, a, b)) begin
        failures++;
        $display("FAIL random_data op=%0d a=%h b=%h got=%h exp=%h", op, a, b, d,
                 ref_div(op, a, b));
      end
      checks++;
      if (lat != ref_latency(op, a, b)) begin
        failures++;
        $display("FAIL random_latency op=%0d got=%0d exp=%0d", op, lat, ref_latency(op, a, b));
      end
    end
  endtask

  task automatic test_back_to_back();
    int          w;
    logic [31:0] held;
    @(negedge clk);
    req_valid = 1'b1;
    req_op = 2'b01;
    req_a = 32'd1000;
    req_b = 32'd9;
    @(negedge clk);
    // second request (DIVU 9/3) held from here on
    req_a = 32'd9;
    req_b = 32'd3;
    w = 0;
    while (!resp_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (!resp_valid) begin
      failures++;
      $display("FAIL bp_timeout resp_valid never rose");
      req_valid = 1'b0;
      return;
    end
    held = resp_data;
    checks++;
    if (held !== 32'd111) begin
      failures++;
      $display("FAIL bp_first_data got=%h exp=%h", held, 32'd111);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (resp_data !== held || resp_valid !== 1'b1 || req_ready !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d data=%h valid=%b ready=%b busy=%b exp data=%h 1 0 1",
                 i, resp_data, resp_valid, req_ready, busy, held);
      end
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL bp_release ready=%b valid=%b busy=%b exp 1 0 0", req_ready, resp_valid, busy);
    end
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_second_accept busy=%b ready=%b exp 1 0", busy, req_ready);
    end
    w = 1;
    while (!resp_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (resp_data !== 32'd3 || w != 33) begin
      failures++;
      $display("FAIL bp_second_result data=%h lat=%0d exp 00000003 33", resp_data, w);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_ready_held();
    int hi;
    resp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b1;
    req_op = 2'b11;
    req_a = 32'd77;
    req_b = 32'd10;
    @(negedge clk);
    req_valid = 1'b0;
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        hi++;
        checks++;
        if (resp_data !== 32'd7) begin
          failures++;
          $display("FAIL held_data got=%h exp=00000007", resp_data);
        end
      end
    end
    resp_ready = 1'b0;
    checks++;
    if (hi != 1) begin
      failures++;
      $display("FAIL held_done_cycles got=%0d exp=1", hi);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int          lat;
    bit          to;
    @(negedge clk);
    req_valid = 1'b1;
    req_op = 2'b00;
    req_a = 32'hFFFF_0000;
    req_b = 32'd13;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_state ready=%b valid=%b busy=%b exp 1 0 0",
               req_ready, resp_valid, busy);
    end
    run_op(2'b01, 32'd9, 32'd3, d, lat, to);
    checks++;
    if (to || d !== 32'd3 || lat != 33) begin
      failures++;
      $display("FAIL midreset_next to=%0d data=%h lat=%0d exp 0 00000003 33", to, d, lat);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    req_valid = 1'b0;
    req_op = 2'b00;
    req_a = '0;
    req_b = '0;
    resp_ready = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_ready_held();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_seq.md
# div_seq

Multi-cycle radix-2 restoring divider for the RV32M divide group (DIV, DIVU, REM, REMU). It is the handshaked responder that replaces the single-cycle combinational divide path: the core issues an operand request, stalls, and collects a 32-bit result. The core sits on the request side and the execute stage consumes the response. One request is in flight at a time.

## Interface
Parameters:
- none; data width is fixed at 32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request; high only in IDLE.
- req_op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- req_a  input  32  dividend.
- req_b  input  32  divisor.
- resp_valid  output  1  result available; high only in DONE.
- resp_ready  input  1  consumer accepts the result.
- resp_data  output  32  quotient for DIV/DIVU, remainder for REM/REMU.
- busy  output  1  high in CALC or DONE.

## Operation
- States: IDLE, CALC, DONE.
- IDLE -> CALC on req_valid && req_ready when the request is not a special case.
  - At acceptance, latch op.
  - For signed ops, latch |a| and |b|, plus q_neg = a[31]^b[31] and r_neg = a[31].
  - For unsigned ops, latch a and b unchanged, with q_neg = r_neg = 0.
  - Set quotient register = |a|, partial remainder = 0, count = 0.
- IDLE -> DONE directly on acceptance of a special case. The result is written in the same edge.
  - Divide by zero (b == 0): DIV/DIVU gives 0xFFFFFFFF; REM/REMU gives a.
  - Signed overflow (DIV/REM with a == 0x80000000 and b == 0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- CALC performs one iteration per cycle, 32 iterations in total.
  - Shift {rem, quo} left by 1.
  - Trial value t = rem_shifted − divisor, computed 33 bits wide.
  - If t is non-negative, rem = t[31:0] and quo[0] = 1. Otherwise rem is kept and quo[0] = 0.
  - count increments each iteration.
- CALC -> DONE after the iteration with count == 31.
  - On that edge, apply signs: quotient is negated if q_neg; remainder is negated if r_neg (two's complement, 32-bit wrap).
  - Select the quotient or remainder by op into the result register.
- DONE -> IDLE on resp_ready. resp_data holds stable while resp_valid && !resp_ready.
- Requests presented while not in IDLE are ignored (req_ready = 0). The requester must hold them.
- Arithmetic is unsigned on magnitudes. |0x80000000| = 0x80000000 as unsigned 32-bit, which is correct for non-overflow cases.

## Timing
- Reset: state = IDLE, req_ready = 1, resp_valid = 0, resp_data = 0, busy = 0, count = 0.
- rst overrides everything, including mid-CALC and in DONE with resp_valid high. An in-flight result is discarded with no response.
- Normal latency: acceptance edge at cycle 0; resp_valid rises after edge 33 (32 CALC cycles + sign/select edge folded into the last iteration, plus the DONE register).
- Special-case latency: resp_valid high after edge 1, i.e. the cycle after acceptance.
- Throughput: the earliest next acceptance is the cycle after the DONE->IDLE edge. No back-to-back accept while in DONE.
- resp_ready may be held high constantly; the block then spends exactly one cycle in DONE.
- Outputs are registered. req_ready is decoded from state only, with no combinational path from req_valid.
- Inputs are sampled only on the acceptance edge. Changes to req_a, req_b and req_op afterwards have no effect.

## Test plan
- DIVU 100 / 7 -> resp_data = 14 (0x0000000E), resp_valid exactly 33 cycles after acceptance; REMU same operands -> 2.
- DIV 0xFFFFFFF9 (−7) / 2 -> 0xFFFFFFFD (−3); REM same operands -> 0xFFFFFFFF (−1); DIVU 0xFFFFFFFF / 2 -> 0x7FFFFFFF.
- Divide by zero: DIV 5 / 0 -> 0xFFFFFFFF, REMU 5 / 0 -> 5; both give resp_valid 1 cycle after acceptance.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0; both take 1 cycle.
- Backpressure: hold resp_ready = 0 for 10 cycles in DONE. resp_data stays stable, req_ready stays 0, and a second req_valid is not accepted until the cycle after resp_ready is asserted.
- Reset mid-operation: assert rst at CALC iteration 15. The next cycle shows IDLE, req_ready = 1, resp_valid = 0. A new DIVU 9 / 3 then returns 3 with full 33-cycle latency.
